// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light safety monitor.
// Aspect encoding, fault-code constants, lamp decode and transition legality.
package tl_pkg;

  typedef enum logic [2:0] {
    ASP_RED     = 3'd0,
    ASP_GREEN   = 3'd1,
    ASP_YELLOW  = 3'd2,
    ASP_LEFT    = 3'd3,
    ASP_INVALID = 3'd4
  } aspect_t;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_CONFLICT   = 3'd1;
  localparam logic [2:0] FC_NS_INVALID = 3'd2;
  localparam logic [2:0] FC_EW_INVALID = 3'd3;
  localparam logic [2:0] FC_NS_SEQ     = 3'd4;
  localparam logic [2:0] FC_EW_SEQ     = 3'd5;
  localparam logic [2:0] FC_NS_YELLOW  = 3'd6;
  localparam logic [2:0] FC_EW_YELLOW  = 3'd7;

  // Exactly one lit lamp names the aspect; dark or multi-lamp heads are invalid.
  function automatic aspect_t decode_aspect(input logic l, input logic g,
                                            input logic y, input logic r);
    case ({l, g, y, r})
      4'b1000: return ASP_LEFT;
      4'b0100: return ASP_GREEN;
      4'b0010: return ASP_YELLOW;
      4'b0001: return ASP_RED;
      default: return ASP_INVALID;
    endcase
  endfunction

  // Transitions touching INVALID are left to the invalid-aspect check.
  function automatic logic legal_step(input aspect_t p, input aspect_t c,
                                      input logic emg);
    if (p == ASP_INVALID || c == ASP_INVALID || p == c) return 1'b1;
    case (p)
      ASP_RED:    return (c == ASP_GREEN) || (c == ASP_LEFT);
      ASP_LEFT:   return (c == ASP_GREEN) || (c == ASP_YELLOW) || (emg && c == ASP_RED);
      ASP_GREEN:  return (c == ASP_YELLOW) || (emg && c == ASP_RED);
      ASP_YELLOW: return (c == ASP_RED);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tl_head_checker.sv
// Per-head checker: aspect decode, previous-aspect register, sequence check
// and (when TLMON_SHORT_YELLOW_EN is defined) the consecutive-yellow counter.
module tl_head_checker
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    emergency,
  input  logic    lamp_l,
  input  logic    lamp_g,
  input  logic    lamp_y,
  input  logic    lamp_r,
  output aspect_t aspect,
  output logic    invalid,
  output logic    seq_err,
  output logic    short_y
);

  aspect_t prev;

  assign aspect  = decode_aspect(lamp_l, lamp_g, lamp_y, lamp_r);
  assign invalid = (aspect == ASP_INVALID);
  assign seq_err = !legal_step(prev, aspect, emergency);

  // Track the last sampled aspect every cycle; reset assumes the head was red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= ASP_RED;
    else     prev <= aspect;
  end

`ifdef TLMON_SHORT_YELLOW_EN
  localparam int CNT_W = $clog2(MIN_YELLOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(MIN_YELLOW_CYCLES);

  logic [CNT_W-1:0] y_cnt;

  // Count consecutive yellow samples, saturating at the minimum length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      y_cnt <= '0;
    else if (aspect == ASP_YELLOW) begin
      if (y_cnt != Y_MAX)         y_cnt <= y_cnt + 1'b1;
    end
    else                          y_cnt <= '0;
  end

  // y_cnt already includes the final yellow sample when red appears.
  assign short_y = (prev == ASP_YELLOW) && (aspect == ASP_RED) &&
                   (y_cnt < Y_MAX) && !emergency;
`else
  localparam int unused_min_yellow = MIN_YELLOW_CYCLES;
  assign short_y = 1'b0;
`endif

endmodule

// File: rtl/trafficlight_monitor.sv
// Independent safety monitor on the eight lamp outputs of the traffic-light
// controller. Latches the first violation as a fault code and requests
// flashing-red. Macro TLMON_SHORT_YELLOW_EN enables short-yellow detection.
module trafficlight_monitor
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       clear_fault,
  input  logic       LeftTurn_NS,
  input  logic       Green_NS,
  input  logic       Yellow_NS,
  input  logic       Red_NS,
  input  logic       LeftTurn_EW,
  input  logic       Green_EW,
  input  logic       Yellow_EW,
  input  logic       Red_EW,
  output logic       fault,
  output logic       flash,
  output logic [2:0] fault_code,
  output logic [7:0] violations
);

  aspect_t    ns_aspect, ew_aspect;
  logic       ns_invalid, ew_invalid;
  logic       ns_seq, ew_seq;
  logic       ns_short, ew_short;
  logic       conflict;
  logic       any_viol;
  logic [2:0] code_now;

  tl_head_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_ns (
    .clk(clk), .rst(rst), .emergency(emergency),
    .lamp_l(LeftTurn_NS), .lamp_g(Green_NS), .lamp_y(Yellow_NS), .lamp_r(Red_NS),
    .aspect(ns_aspect), .invalid(ns_invalid), .seq_err(ns_seq), .short_y(ns_short)
  );

  tl_head_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_ew (
    .clk(clk), .rst(rst), .emergency(emergency),
    .lamp_l(LeftTurn_EW), .lamp_g(Green_EW), .lamp_y(Yellow_EW), .lamp_r(Red_EW),
    .aspect(ew_aspect), .invalid(ew_invalid), .seq_err(ew_seq), .short_y(ew_short)
  );

  assign conflict = (ns_aspect != ASP_RED) && (ew_aspect != ASP_RED) &&
                    !ns_invalid && !ew_invalid;

  // Lowest-numbered violation wins when several coincide.
  always_comb begin
    code_now = FC_NONE;
    if      (conflict)   code_now = FC_CONFLICT;
    else if (ns_invalid) code_now = FC_NS_INVALID;
    else if (ew_invalid) code_now = FC_EW_INVALID;
    else if (ns_seq)     code_now = FC_NS_SEQ;
    else if (ew_seq)     code_now = FC_EW_SEQ;
    else if (ns_short)   code_now = FC_NS_YELLOW;
    else if (ew_short)   code_now = FC_EW_YELLOW;
  end

  assign any_viol = (code_now != FC_NONE);
  assign flash    = fault;

  // Fault latch: first violation sticks; clear only succeeds on a clean cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end
    else if (!fault && any_viol) begin
      fault      <= 1'b1;
      fault_code <= code_now;
    end
    else if (fault && clear_fault && !any_viol) begin
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end
  end

  // Saturating count of violating cycles, independent of the latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                violations <= 8'd0;
    else if (any_viol && violations != 8'hFF) violations <= violations + 8'd1;
  end

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Scoreboard bench for trafficlight_monitor: directed lamp vectors push
// hand-computed expectations; a monitor pops and compares every cycle.
module tb_trafficlight_monitor;

`ifdef TLMON_SHORT_YELLOW_EN
  localparam int SY = 1;
`else
  localparam int SY = 0;
`endif

  localparam logic [3:0] R  = 4'b0001;
  localparam logic [3:0] Y  = 4'b0010;
  localparam logic [3:0] G  = 4'b0100;
  localparam logic [3:0] L  = 4'b1000;
  localparam logic [3:0] D  = 4'b0000;
  localparam logic [3:0] RY = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic emergency = 1'b0;
  logic clear_fault = 1'b0;
  logic LeftTurn_NS = 1'b0, Green_NS = 1'b0, Yellow_NS = 1'b0, Red_NS = 1'b1;
  logic LeftTurn_EW = 1'b0, Green_EW = 1'b0, Yellow_EW = 1'b0, Red_EW = 1'b1;
  logic       fault, flash;
  logic [2:0] fault_code;
  logic [7:0] violations;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       f;
    logic [2:0] c;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  trafficlight_monitor #(.MIN_YELLOW_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .emergency(emergency), .clear_fault(clear_fault),
    .LeftTurn_NS(LeftTurn_NS), .Green_NS(Green_NS), .Yellow_NS(Yellow_NS), .Red_NS(Red_NS),
    .LeftTurn_EW(LeftTurn_EW), .Green_EW(Green_EW), .Yellow_EW(Yellow_EW), .Red_EW(Red_EW),
    .fault(fault), .flash(flash), .fault_code(fault_code), .violations(violations)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one cycle of lamps and record what the outputs must be after the edge.
  task automatic step(input logic [3:0] ns, input logic [3:0] ew,
                      input logic emg, input logic clr,
                      input logic ef, input logic [2:0] ec, input int ev);
    exp_t e;
    @(negedge clk);
    {LeftTurn_NS, Green_NS, Yellow_NS, Red_NS} = ns;
    {LeftTurn_EW, Green_EW, Yellow_EW, Red_EW} = ew;
    emergency   = emg;
    clear_fault = clr;
    e.f = ef;
    e.c = ec;
    e.v = 8'(ev);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  // Monitor: compare outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("fault", int'(fault), int'(e.f));
        check("flash", int'(flash), int'(e.f));
        check("fault_code", int'(fault_code), int'(e.c));
        check("violations", int'(violations), int'(e.v));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_fault", int'(fault), 0);
    check("rst_flash", int'(flash), 0);
    check("rst_code", int'(fault_code), 0);
    check("rst_viol", int'(violations), 0);
    rst = 1'b0;

    // Legal NS cycle, then EW cycle
    step(L, R, 0, 0, 0, 0, 0);
    step(G, R, 0, 0, 0, 0, 0);
    step(Y, R, 0, 0, 0, 0, 0);
    step(Y, R, 0, 0, 0, 0, 0);
    step(Y, R, 0, 0, 0, 0, 0);
    step(R, R, 0, 0, 0, 0, 0);
    step(R, L, 0, 0, 0, 0, 0);
    step(R, G, 0, 0, 0, 0, 0);
    step(R, Y, 0, 0, 0, 0, 0);
    step(R, Y, 0, 0, 0, 0, 0);
    step(R, Y, 0, 0, 0, 0, 0);
    step(R, R, 0, 0, 0, 0, 0);

    // Conflict, hold, clear refused during conflict, clear accepted
    step(G, R, 0, 0, 0, 0, 0);
    step(G, G, 0, 0, 1, 1, 1);
    step(G, R, 1, 0, 1, 1, 1);
    step(G, G, 0, 1, 1, 1, 2);
    step(G, R, 1, 1, 0, 0, 2);
    step(G, R, 0, 0, 0, 0, 2);

    // Both dark, then an NS sequence error: code 2 holds, count keeps going
    step(D, D, 0, 0, 1, 2, 3);
    step(G, R, 0, 0, 1, 2, 3);
    step(R, R, 0, 0, 1, 2, 4);
    step(R, R, 0, 1, 0, 0, 4);

    // Emergency preemption legal, then the same without emergency
    step(G, R, 0, 0, 0, 0, 4);
    step(R, R, 1, 0, 0, 0, 4);
    step(G, R, 0, 0, 0, 0, 4);
    step(R, R, 0, 0, 1, 4, 5);
    step(R, R, 0, 1, 0, 0, 5);

    // EW yellow for only two samples
    step(R, G, 0, 0, 0, 0, 5);
    step(R, Y, 0, 0, 0, 0, 5);
    step(R, Y, 0, 0, 0, 0, 5);
    step(R, R, 0, 0, 1'(SY), (SY != 0) ? 3'd7 : 3'd0, 5 + SY);
    step(R, R, 0, 1, 0, 0, 5 + SY);

    // Same-cycle NS sequence error and EW invalid: EW invalid (3) wins
    step(G, R,  0, 0, 0, 0, 5 + SY);
    step(R, RY, 0, 0, 1, 3, 6 + SY);
    step(R, R,  0, 0, 1, 3, 6 + SY);
    step(R, R,  0, 1, 0, 0, 6 + SY);

    // EW sequence error R->Y, then recover under emergency while clearing
    step(R, Y, 0, 0, 1, 5, 7 + SY);
    step(R, R, 1, 1, 0, 0, 7 + SY);

    // Conflict, then asynchronous reset mid-fault
    step(G, G, 0, 0, 1, 1, 8 + SY);
    drain();
    #2;
    rst = 1'b1;
    #1;
    check("arst_fault", int'(fault), 0);
    check("arst_flash", int'(flash), 0);
    check("arst_code", int'(fault_code), 0);
    check("arst_viol", int'(violations), 0);
    {LeftTurn_NS, Green_NS, Yellow_NS, Red_NS} = R;
    {LeftTurn_EW, Green_EW, Yellow_EW, Red_EW} = R;
    @(negedge clk);
    rst = 1'b0;

    // First sample after reset is checked against red: R->Y is illegal
    step(Y, R, 0, 0, 1, 4, 1);

    // Violation counter saturates at 255
    for (int i = 0; i < 260; i++)
      step(D, D, 0, 0, 1, 4, (2 + i > 255) ? 255 : 2 + i);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trafficlight_monitor.md
# trafficlight_monitor

Independent safety monitor on the lamp outputs of the `trafficlight` controller: the receiving end of the eight lamp signals. It samples both signal heads every clock and checks for illegal aspects, NS/EW conflicts, illegal aspect sequences and short yellows. On the first violation it latches a fault and a fault code, and drives `flash` so the cabinet can force flashing-red. It sits beside the controller in the intersection top level and shares its clock, reset and `emergency` input.

## Interface
- `MIN_YELLOW_CYCLES`, default 3: minimum number of consecutive samples a head must show yellow before red.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `emergency`  in  1  preemption request, the same signal the controller sees; relaxes the sequence rules (see Operation).
- `clear_fault`  in  1  synchronous single-cycle request to unlatch a fault.
- `LeftTurn_NS`, `Green_NS`, `Yellow_NS`, `Red_NS`  in  1 each  NS head lamps.
- `LeftTurn_EW`, `Green_EW`, `Yellow_EW`, `Red_EW`  in  1 each  EW head lamps.
- `fault`  out  1  latched fault.
- `flash`  out  1  equal to `fault`; the flashing-red request to the cabinet.
- `fault_code`  out  3  code of the first latched violation.
- `violations`  out  8  saturating count of cycles with any violation present.

## Operation
- **Aspect decode, per head:**
  - Exactly one lamp lit gives an aspect of L, G, Y or R.
  - Zero lamps, or two or more lamps, gives INVALID.
- **Per-head state:**
  - `prev` holds the last sampled aspect; it resets to R.
  - A yellow counter counts consecutive Y samples and saturates at `MIN_YELLOW_CYCLES`.
- **Fault codes, in priority order.** When several violations occur in one cycle, the lowest code wins.
  - 1 = conflict: neither head is R, and neither is INVALID.
  - 2 = NS INVALID aspect.
  - 3 = EW INVALID aspect.
  - 4 = NS illegal sequence.
  - 5 = EW illegal sequence.
  - 6 = NS short yellow.
  - 7 = EW short yellow.
  - 0 = no fault.
- **Legal transitions (prev → current):**
  - Any aspect → itself.
  - R→G, R→L, L→G, L→Y, G→Y, Y→R.
  - When `emergency`=1, L→R and G→R are also legal.
  - Every other transition is a sequence violation.
  - A transition out of INVALID is not checked.
- **Short yellow:** a Y→R transition where the yellow counter is below `MIN_YELLOW_CYCLES` and `emergency`=0.
- **Latch behaviour:**
  - If `fault`=0 and any violation is present, set `fault` and load `fault_code`.
  - While `fault`=1, the code holds and later violations do not overwrite it.
- **`clear_fault`:**
  - When `clear_fault`=1 and no violation is present that cycle, clear `fault` and set `fault_code` to 0.
  - If a violation is present in that same cycle, the latch stays set and the code is unchanged.
- **`violations`:** increments on every cycle with any violation present, whether or not a fault is latched, and saturates at 255. Only `rst` clears it.
- **`prev` and yellow counters:** update every cycle regardless of the fault state.

## Timing
- **Reset values:** `fault`=0, `flash`=0, `fault_code`=0, `violations`=0, both `prev`=R, both yellow counters 0.
- **Reset mid-operation:** asynchronous and immediate. The first sample after reset is checked against R.
- **Detection latency:** violation checks are combinational on the current lamp inputs against `prev`. A violation present before rising edge N shows `fault`=1 after edge N.
- **Transient violations:** a one-cycle violation still latches.
- **Yellow counting:** the Y sample on the Y→R edge is already counted. Y held for exactly `MIN_YELLOW_CYCLES` samples followed by R is legal.
- **Clear latency:** `clear_fault` sampled at edge N gives `fault`=0 after edge N.

## Configuration
- **`TLMON_SHORT_YELLOW_EN` defined:** codes 6 and 7 are checked, and the yellow counters are built.
- **`TLMON_SHORT_YELLOW_EN` undefined:**
  - The counters are removed and `MIN_YELLOW_CYCLES` is ignored.
  - Y→R is always legal.
  - Codes 6 and 7 are never produced.

## Structure
- **Package `tl_pkg`:**
  - Aspect enum: `ASP_RED`, `ASP_GREEN`, `ASP_YELLOW`, `ASP_LEFT`, `ASP_INVALID`.
  - 3-bit fault code constants, `FC_NONE` through `FC_EW_YELLOW`.
- **Sub-module `tl_head_checker`, instantiated twice (NS and EW):**
  - Contains the aspect decode, the `prev` register, the sequence check and the yellow counter.
  - Outputs `aspect`, `invalid`, `seq_err` and `short_y`.
- **Top level:** holds the conflict check, the priority encoder, the fault latch and the violation counter.

## Test plan
- **Legal cycle:** NS R→L→G→Y(3 cycles)→R while EW is R, then mirrored for EW → `fault`=0 and `violations`=0 throughout.
- **Conflict:** NS=G and EW=G for one cycle → `fault`=1 and `fault_code`=1 after that edge; the code holds after lamps return to legal.
- **Multiple violations:** both heads dark, plus NS G→R with `emergency`=0 on a later cycle → `fault_code`=2 stays; `violations` counts every offending cycle.
- **Emergency preemption:** NS G→R with `emergency`=1 → no fault. Repeat with `emergency`=0 → `fault_code`=4.
- **Short yellow (macro defined):** EW Y held 2 cycles then R → `fault_code`=7. With the macro undefined, the same stimulus gives no fault.
- **Clear and reset:**
  - `clear_fault` during an active conflict → `fault` stays 1.
  - `clear_fault` after lamps are legal → `fault`=0 and `fault_code`=0 next edge.
  - Asynchronous `rst` mid-fault → all outputs 0 immediately.
